// File: rtl/mpi_master_arbiter_if.sv
// Requester-side handshake plus the bus pins of the two-requester bus master.
// The master modport belongs to the arbiter; slave is the requesters/responder side.
interface mpi_master_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [1:0]  bytew;
  logic [15:0] addr0;
  logic [15:0] addr1;
  logic [15:0] wdata0;
  logic [15:0] wdata1;
  logic [1:0]  ack;
  logic [1:0]  err;
  logic [15:0] rdata;
  logic [15:0] nAD_o;
  logic        nAD_oe;
  logic [15:0] nAD_i;
  logic        nSYNC_o;
  logic        nDIN_o;
  logic        nDOUT_o;
  logic        nWTBT_o;
  logic        nSYNC_oe;
  logic        ctrl_oe;
  logic        nBSY_o;
  logic        nRPLY_i;

  modport master (
    input  req, we, bytew, addr0, addr1, wdata0, wdata1, nAD_i, nRPLY_i,
    output ack, err, rdata, nAD_o, nAD_oe, nSYNC_o, nDIN_o, nDOUT_o, nWTBT_o,
           nSYNC_oe, ctrl_oe, nBSY_o
  );

  modport slave (
    output req, we, bytew, addr0, addr1, wdata0, wdata1, nAD_i, nRPLY_i,
    input  ack, err, rdata, nAD_o, nAD_oe, nSYNC_o, nDIN_o, nDOUT_o, nWTBT_o,
           nSYNC_oe, ctrl_oe, nBSY_o
  );
endinterface

// File: rtl/mpi_master_arbiter.sv
// Two-requester round-robin bus master: runs one address/data cycle per grant with a
// double-sampled reply handshake and a timeout abort. Every output is registered.
module mpi_master_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic                CLKp,
  input  logic                RSTp,
  mpi_master_arbiter_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ADDR, SYNC, DATA, STRB, RWAIT, REL, FIN} state_t;

  typedef struct packed {
    logic        gnt;
    logic        we;
    logic        bytew;
    logic [15:0] addr;
    logic [15:0] wdata;
  } xfer_t;

  typedef struct packed {
    logic [15:0] nad;
    logic        nad_oe;
    logic        ctrl_oe;
    logic        sync_oe;
    logic        nsync;
    logic        ndin;
    logic        ndout;
    logic        nwtbt;
    logic        nbsy;
  } drv_t;

  localparam drv_t DRV_IDLE = '{nad: 16'hFFFF, nad_oe: 1'b0, ctrl_oe: 1'b0, sync_oe: 1'b0,
                                nsync: 1'b1, ndin: 1'b1, ndout: 1'b1, nwtbt: 1'b1,
                                nbsy: 1'b1};

  state_t      state, state_nx;
  xfer_t       cur, cur_nx;
  drv_t        drv, drv_nx;
  logic        last, last_nx;
  logic [CW-1:0] tmo, tmo_nx;
  logic        rply_seen, rply_nx;
  logic [15:0] rdata_q, rdata_nx;
  logic [1:0]  ack_q, ack_nx;
  logic [1:0]  err_q, err_nx;
  logic        g;
  logic        abort;

  always_ff @(posedge CLKp or posedge RSTp) begin
    if (RSTp) begin
      state     <= IDLE;
      cur       <= '0;
      drv       <= DRV_IDLE;
      last      <= 1'b1;
      tmo       <= '0;
      rply_seen <= 1'b0;
      rdata_q   <= '0;
      ack_q     <= '0;
      err_q     <= '0;
    end else begin
      state     <= state_nx;
      cur       <= cur_nx;
      drv       <= drv_nx;
      last      <= last_nx;
      tmo       <= tmo_nx;
      rply_seen <= rply_nx;
      rdata_q   <= rdata_nx;
      ack_q     <= ack_nx;
      err_q     <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cur_nx   = cur;
    last_nx  = last;
    tmo_nx   = tmo;
    rply_nx  = rply_seen;
    rdata_nx = rdata_q;
    ack_nx   = '0;
    err_nx   = '0;
    drv_nx   = DRV_IDLE;
    g        = 1'b0;
    abort    = 1'b0;

    // Timeout window spans DATA through RWAIT; the abort edge is the one that
    // would carry the counter to TIMEOUT.
    if (state == DATA || state == STRB || state == RWAIT) begin
      tmo_nx = tmo + 1'b1;
      abort  = (tmo == TMO_LAST);
    end

    case (state)
      IDLE: begin
        if (|bus.req) begin
          case (bus.req)
            2'b01:   g = 1'b0;
            2'b10:   g = 1'b1;
            2'b11:   g = ~last;
            default: g = 1'b0;
          endcase
          cur_nx.gnt   = g;
          cur_nx.we    = bus.we[g];
          cur_nx.bytew = bus.bytew[g];
          cur_nx.addr  = g ? bus.addr1 : bus.addr0;
          cur_nx.wdata = g ? bus.wdata1 : bus.wdata0;
          rply_nx      = 1'b0;
          state_nx     = ADDR;
        end
      end
      ADDR: begin
        tmo_nx   = '0;
        state_nx = SYNC;
      end
      SYNC: state_nx = DATA;
      DATA: begin
        rply_nx  = 1'b0;
        state_nx = STRB;
      end
      STRB: begin
        // Reply must be seen low on two consecutive samples before the strobe drops.
        if (!bus.nRPLY_i) begin
          if (rply_seen) begin
            rply_nx  = 1'b0;
            state_nx = RWAIT;
            if (!cur.we) rdata_nx = ~bus.nAD_i;
          end else begin
            rply_nx = 1'b1;
          end
        end else begin
          rply_nx = 1'b0;
        end
      end
      RWAIT: begin
        if (bus.nRPLY_i) begin
          if (rply_seen) begin
            rply_nx  = 1'b0;
            state_nx = REL;
          end else begin
            rply_nx = 1'b1;
          end
        end else begin
          rply_nx = 1'b0;
        end
      end
      REL: begin
        last_nx         = cur.gnt;
        ack_nx[cur.gnt] = 1'b1;
        state_nx        = FIN;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    if (abort) begin
      state_nx        = IDLE;
      rply_nx         = 1'b0;
      rdata_nx        = rdata_q;
      last_nx         = cur.gnt;
      err_nx[cur.gnt] = 1'b1;
    end

    // Pin values are decoded from the state being entered so they register with it.
    case (state_nx)
      ADDR, SYNC: begin
        drv_nx.nbsy    = 1'b0;
        drv_nx.nad     = ~cur_nx.addr;
        drv_nx.nad_oe  = 1'b1;
        drv_nx.ctrl_oe = 1'b1;
        drv_nx.sync_oe = 1'b1;
        drv_nx.nwtbt   = ~cur_nx.we;
        drv_nx.nsync   = (state_nx == ADDR);
      end
      DATA, STRB, RWAIT: begin
        drv_nx.nbsy    = 1'b0;
        drv_nx.ctrl_oe = 1'b1;
        drv_nx.sync_oe = 1'b1;
        drv_nx.nsync   = 1'b0;
        drv_nx.nwtbt   = 1'b1;
        if (state_nx != RWAIT && cur_nx.we) begin
          drv_nx.nad    = ~cur_nx.wdata;
          drv_nx.nad_oe = 1'b1;
        end
        if (state_nx == STRB) begin
          if (cur_nx.we) begin
            drv_nx.ndout = 1'b0;
            drv_nx.nwtbt = ~cur_nx.bytew;
          end else begin
            drv_nx.ndin = 1'b0;
          end
        end
      end
      REL:     drv_nx.sync_oe = 1'b1;
      default: ;
    endcase
  end

  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.rdata    = rdata_q;
  assign bus.nAD_o    = drv.nad;
  assign bus.nAD_oe   = drv.nad_oe;
  assign bus.ctrl_oe  = drv.ctrl_oe;
  assign bus.nSYNC_oe = drv.sync_oe;
  assign bus.nSYNC_o  = drv.nsync;
  assign bus.nDIN_o   = drv.ndin;
  assign bus.nDOUT_o  = drv.ndout;
  assign bus.nWTBT_o  = drv.nwtbt;
  assign bus.nBSY_o   = drv.nbsy;
endmodule

// File: tb/tb_mpi_master_arbiter.sv
// Directed bench: stimulus pushes expected pin values and completions into queues,
// a negedge monitor pops and compares them against the arbiter.
module tb_mpi_master_arbiter;
  localparam int T = 64;

  logic CLKp = 1'b0;
  logic RSTp = 1'b0;
  int   cyc = 0;
  logic resp_en = 1'b0;
  logic glitch = 1'b0;
  logic [15:0] rd_val = '0;
  logic [15:0] exp_rd = '0;
  bit   wrap = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  mpi_master_arbiter_if bus ();

  mpi_master_arbiter #(.TIMEOUT(T)) dut (
    .CLKp (CLKp),
    .RSTp (RSTp),
    .bus  (bus)
  );

  always #5 CLKp = ~CLKp;
  always @(posedge CLKp) cyc <= cyc + 1;

  // Responder: replies while a strobe is low, returns rd_val on reads.
  assign bus.nRPLY_i = glitch ? 1'b0 : (resp_en ? (bus.nDOUT_o & bus.nDIN_o) : 1'b1);
  assign bus.nAD_i   = (resp_en && !bus.nDIN_o) ? ~rd_val
                                                 : (bus.nAD_oe ? bus.nAD_o : 16'hFFFF);

  typedef enum {F_NAD, F_NADOE, F_NWTBT, F_NDOUT, F_NDIN, F_NSYNC, F_NBSY, F_CTRLOE,
                F_SYNCOE, F_RDATA, F_ACK, F_ERR} fld_t;
  typedef struct {int due; fld_t f; logic [15:0] v; string name;} bchk_t;
  typedef struct {int due; bit is_err; int idx; logic [15:0] rd; string name;} done_t;

  bchk_t bq[$];
  done_t dq[$];

  function automatic logic [15:0] get(fld_t f);
    case (f)
      F_NAD:    return bus.nAD_o;
      F_NADOE:  return {15'b0, bus.nAD_oe};
      F_NWTBT:  return {15'b0, bus.nWTBT_o};
      F_NDOUT:  return {15'b0, bus.nDOUT_o};
      F_NDIN:   return {15'b0, bus.nDIN_o};
      F_NSYNC:  return {15'b0, bus.nSYNC_o};
      F_NBSY:   return {15'b0, bus.nBSY_o};
      F_CTRLOE: return {15'b0, bus.ctrl_oe};
      F_SYNCOE: return {15'b0, bus.nSYNC_oe};
      F_RDATA:  return bus.rdata;
      F_ACK:    return {14'b0, bus.ack};
      default:  return {14'b0, bus.err};
    endcase
  endfunction

  function automatic void bx(int due, fld_t f, logic [15:0] v, string name);
    bchk_t e;
    e.due = due; e.f = f; e.v = v; e.name = name;
    bq.push_back(e);
  endfunction

  function automatic void dx(int due, bit is_err, int idx, logic [15:0] rd, string name);
    done_t d;
    d.due = due; d.is_err = is_err; d.idx = idx; d.rd = rd; d.name = name;
    dq.push_back(d);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLKp);
      #1;
    end
  endtask

  // Checked at the coming negedge, i.e. before the next clock edge.
  task automatic reset_checks(input string tag);
    int c;
    c = cyc;
    bx(c, F_NAD,    16'hFFFF, {tag, ".nad"});
    bx(c, F_NADOE,  16'd0,    {tag, ".nad_oe"});
    bx(c, F_CTRLOE, 16'd0,    {tag, ".ctrl_oe"});
    bx(c, F_SYNCOE, 16'd0,    {tag, ".sync_oe"});
    bx(c, F_NSYNC,  16'd1,    {tag, ".nsync"});
    bx(c, F_NDIN,   16'd1,    {tag, ".ndin"});
    bx(c, F_NDOUT,  16'd1,    {tag, ".ndout"});
    bx(c, F_NWTBT,  16'd1,    {tag, ".nwtbt"});
    bx(c, F_NBSY,   16'd1,    {tag, ".nbsy"});
    bx(c, F_RDATA,  16'd0,    {tag, ".rdata"});
    bx(c, F_ACK,    16'd0,    {tag, ".ack"});
    bx(c, F_ERR,    16'd0,    {tag, ".err"});
  endtask

  // Grant edge is c+1; ADDR c+1, SYNC c+2, DATA c+3, STRB c+4, REL c+8, FIN/ack c+9.
  // A one-clock reply glitch in RWAIT pushes REL/FIN two clocks later.
  task automatic xfer(input int idx, input bit w, input bit bw, input logic [15:0] a,
                      input logic [15:0] wd, input logic [15:0] rd, input string tag,
                      input bit glt);
    int c;
    int fin;
    c = cyc;
    fin = c + 9 + (glt ? 2 : 0);
    if (idx == 0) begin bus.addr0 = a; bus.wdata0 = wd; end
    else          begin bus.addr1 = a; bus.wdata1 = wd; end
    bus.we[idx] = w;
    bus.bytew[idx] = bw;
    rd_val = rd;
    resp_en = 1'b1;
    if (!w) exp_rd = rd;
    bx(c + 1, F_NAD,   ~a,           {tag, ".addr"});
    bx(c + 1, F_NWTBT, {15'b0, !w},  {tag, ".addr_wtbt"});
    bx(c + 1, F_NBSY,  16'd0,        {tag, ".bsy"});
    bx(c + 2, F_NSYNC, 16'd0,        {tag, ".sync"});
    if (w) begin
      bx(c + 3, F_NAD,   ~wd,          {tag, ".data"});
      bx(c + 4, F_NDOUT, 16'd0,        {tag, ".dout"});
      bx(c + 4, F_NWTBT, {15'b0, !bw}, {tag, ".strb_wtbt"});
    end else begin
      bx(c + 3, F_NADOE, 16'd0, {tag, ".data_oe"});
      bx(c + 4, F_NDIN,  16'd0, {tag, ".din"});
    end
    bx(fin - 1, F_NBSY,   16'd1, {tag, ".rel_bsy"});
    bx(fin - 1, F_CTRLOE, 16'd0, {tag, ".rel_ctrl_oe"});
    bx(fin,     F_SYNCOE, 16'd0, {tag, ".fin_sync_oe"});
    dx(fin, 1'b0, idx, exp_rd, {tag, ".done"});
    bus.req[idx] = 1'b1;
    if (glt) begin
      tick(7); glitch = 1'b1; tick(1); glitch = 1'b0; tick(3);
    end else begin
      tick(9);
    end
    bus.req[idx] = 1'b0;
    tick(2);
  endtask

  initial begin
    int c;
    bus.req = '0; bus.we = '0; bus.bytew = '0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    #1 RSTp = 1'b1;
    tick(2);
    reset_checks("rst");
    tick(1); RSTp = 1'b0; tick(1);

    xfer(0, 1'b1, 1'b0, 16'o177714, 16'h000F, 16'h0000, "wwr", 1'b0);
    xfer(0, 1'b1, 1'b1, 16'o177714, 16'h0055, 16'h0000, "bwr", 1'b0);
    xfer(1, 1'b0, 1'b0, 16'o177560, 16'h0000, 16'h1234, "rd",  1'b0);
    xfer(1, 1'b1, 1'b0, 16'o001000, 16'hA5A5, 16'h0000, "glt", 1'b1);

    // No responder: err at c+T+3 (TIMEOUT+1 after SYNC), bus released with it.
    c = cyc;
    resp_en = 1'b0;
    bus.we[0] = 1'b1; bus.bytew[0] = 1'b0; bus.addr0 = 16'o177700; bus.wdata0 = 16'h00FF;
    bx(c + T + 2, F_NDOUT,  16'd0, "to.still_strb");
    bx(c + T + 3, F_NBSY,   16'd1, "to.bsy");
    bx(c + T + 3, F_CTRLOE, 16'd0, "to.ctrl_oe");
    bx(c + T + 3, F_NADOE,  16'd0, "to.nad_oe");
    bx(c + T + 3, F_SYNCOE, 16'd0, "to.sync_oe");
    bx(c + T + 3, F_NSYNC,  16'd1, "to.nsync");
    bx(c + T + 4, F_NBSY,   16'd1, "to.after_bsy");
    dx(c + T + 3, 1'b1, 0, exp_rd, "to.err");
    bus.req[0] = 1'b1;
    tick(T + 3);
    bus.req[0] = 1'b0;
    tick(3);
    resp_en = 1'b1;

    // Reset in the middle of STRB: no completion, everything released at once.
    c = cyc;
    bus.we[0] = 1'b1; bus.bytew[0] = 1'b0; bus.addr0 = 16'o000400; bus.wdata0 = 16'h1111;
    bx(c + 4, F_NDOUT, 16'd0, "mrst.strb");
    bus.req[0] = 1'b1;
    tick(5);
    RSTp = 1'b1;
    exp_rd = 16'h0000;
    reset_checks("mrst");
    tick(1); bus.req[0] = 1'b0; RSTp = 1'b0; tick(2);
    xfer(0, 1'b1, 1'b0, 16'o000402, 16'h2222, 16'h0000, "post", 1'b0);

    // Ties from reset: 0 then 1; second round keeps req0 high so the pointer decides.
    RSTp = 1'b1;
    reset_checks("rst2");
    tick(1); RSTp = 1'b0; tick(1);
    bus.we = 2'b11; bus.bytew = 2'b00;
    bus.addr0 = 16'o000100; bus.addr1 = 16'o000200;
    bus.wdata0 = 16'h0A0A; bus.wdata1 = 16'h0B0B;
    c = cyc;
    bx(c + 1,  F_NAD, ~16'o000100, "tie1.a0");
    bx(c + 11, F_NAD, ~16'o000200, "tie1.a1");
    dx(c + 9,  1'b0, 0, exp_rd, "tie1.r0");
    dx(c + 19, 1'b0, 1, exp_rd, "tie1.r1");
    bus.req = 2'b11;
    tick(9); bus.req[0] = 1'b0; tick(10); bus.req[1] = 1'b0; tick(1);
    c = cyc;
    bx(c + 1,  F_NAD, ~16'o000100, "tie2.a0");
    bx(c + 11, F_NAD, ~16'o000200, "tie2.a1");
    dx(c + 9,  1'b0, 0, exp_rd, "tie2.r0");
    dx(c + 19, 1'b0, 1, exp_rd, "tie2.r1");
    bus.req = 2'b11;
    tick(19); bus.req = 2'b00; tick(3);

    wrap = 1'b1;
    tick(4);
    $display("FAIL monitor did not close the run");
    $fatal(1);
  end

  always @(negedge CLKp) begin : mon
    bchk_t e;
    done_t d;
    logic [15:0] act;
    logic [1:0] xa, xe;
    while (bq.size() > 0 && bq[0].due <= cyc) begin
      e = bq.pop_front();
      act = get(e.f);
      n_cmp++;
      if (e.due != cyc || act !== e.v) begin
        n_bad++;
        $display("FAIL %s cyc=%0d got=%h want=%h due=%0d", e.name, cyc, act, e.v, e.due);
      end
    end
    if (bus.ack !== 2'b00 || bus.err !== 2'b00) begin
      n_cmp++;
      if (dq.size() == 0) begin
        n_bad++;
        $display("FAIL stray_pulse cyc=%0d got ack=%b err=%b want no pulse", cyc, bus.ack, bus.err);
      end else begin
        d = dq.pop_front();
        xa = '0; xe = '0;
        if (d.is_err) xe[d.idx] = 1'b1; else xa[d.idx] = 1'b1;
        if (bus.ack !== xa || bus.err !== xe || bus.rdata !== d.rd || cyc != d.due) begin
          n_bad++;
          $display("FAIL %s got ack=%b err=%b rdata=%h cyc=%0d want ack=%b err=%b rdata=%h cyc=%0d",
                   d.name, bus.ack, bus.err, bus.rdata, cyc, xa, xe, d.rd, d.due);
        end
      end
    end
    if (wrap) begin
      while (dq.size() > 0) begin
        d = dq.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL %s got no pulse want one at cyc=%0d", d.name, d.due);
      end
      while (bq.size() > 0) begin
        e = bq.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL %s not sampled want=%h at cyc=%0d", e.name, e.v, e.due);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end
endmodule

// File: doc/mpi_master_arbiter.md
MPI_MASTER_ARBITER -- requirements
Module: mpi_master_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: clocks allowed from nSYNC assertion to completion before the cycle is aborted.
REQ-002 CLKp  input  1  system clock; all state changes on its rising edge.
REQ-003 RSTp  input  1  asynchronous reset, active-high.
REQ-004 req  input  2  per-requester cycle request, bit i = requester i; held high until ack[i] or err[i].
REQ-005 we  input  2  per-requester direction: 1 = write (DOUT), 0 = read (DIN).
REQ-006 bytew  input  2  per-requester size: 1 = byte write, 0 = word.
REQ-007 addr0, addr1  input  16  requester word/byte address, true polarity.
REQ-008 wdata0, wdata1  input  16  requester write data, true polarity.
REQ-009 ack  output  2  one-clock completion pulse to the granted requester.
REQ-010 err  output  2  one-clock timeout pulse to the granted requester.
REQ-011 rdata  output  16  read data, true polarity, valid while ack pulses; holds otherwise.
REQ-012 nAD_o  output  16  bus address/data, inverted polarity; nAD_oe  output  1  enable.
REQ-013 nAD_i  input  16  bus AD sampled, inverted polarity.
REQ-014 nSYNC_o, nDIN_o, nDOUT_o, nWTBT_o  output  1 each  bus controls, active-low.
REQ-015 nSYNC_oe  output  1  nSYNC driver enable; ctrl_oe  output  1  enable for nDIN/nDOUT/nWTBT.
REQ-016 nBSY_o  output  1  bus busy, active-low, open-drain: 0 drives, 1 means released.
REQ-017 nRPLY_i  input  1  bus reply, active-low, wired-AND.

Function
REQ-018 States: IDLE, ADDR, SYNC, DATA, STRB, RWAIT, REL, FIN; all outputs registered.
REQ-019 IDLE: if any req bit is high, latch grant, we, bytew, addr and wdata of the granted requester; go to ADDR.
REQ-020 Arbitration: if only one req is high, that requester wins; if both are high, the one not served last wins (round-robin); last-served pointer resets to 1, so requester 0 wins the first tie.
REQ-021 ADDR (1 clk): nBSY_o=0, nAD_o=~addr, nAD_oe=1, ctrl_oe=1, nWTBT_o = ~we, nDIN_o=nDOUT_o=1, nSYNC_oe=1, nSYNC_o=1.
REQ-022 SYNC (1 clk): nSYNC_o=0; start timeout counter at 0.
REQ-023 DATA (1 clk): nWTBT_o=1; for writes nAD_o=~wdata and nAD_oe stays 1; for reads nAD_oe=0.
REQ-024 STRB: write sets nDOUT_o=0 and nWTBT_o=~bytew (byte write gives nWTBT=0); read sets nDIN_o=0; exit after nRPLY_i is sampled low on two consecutive clocks.
REQ-025 STRB exit: deassert strobe; on a read, capture rdata=~nAD_i on the second low sample; go to RWAIT.
REQ-026 RWAIT: nAD_oe=0, nWTBT_o=1; exit to REL after nRPLY_i is sampled high on two consecutive clocks; a single glitch sample restarts the count.
REQ-027 REL (1 clk): ctrl_oe=0, nBSY_o=1, nSYNC_o=1.
REQ-028 FIN (1 clk): nSYNC_oe=0; pulse ack[grant]; update the last-served pointer; return to IDLE. A req still high is re-arbitrated only from the next IDLE clock.
REQ-029 Timeout: the counter increments every clock in DATA/STRB/RWAIT. When it reaches TIMEOUT, go to IDLE in the next clock: all enables=0, nBSY_o=1, nSYNC_o=1, err[grant] pulses one clock, rdata unchanged, pointer updated.
REQ-030 Request changes after grant are ignored until FIN or abort.
REQ-031 ack and err are never both high, never high for a non-granted requester, and never high for more than one clock.

Reset
REQ-032 While RSTp=1 (asynchronous): state=IDLE, ack=err=0, rdata=0, nAD_o=16'hFFFF, nAD_oe=ctrl_oe=nSYNC_oe=0, nSYNC_o=nDIN_o=nDOUT_o=nWTBT_o=nBSY_o=1, pointer=1, counter=0.
REQ-033 Reset mid-cycle releases every bus driver immediately; no ack or err is issued for the interrupted cycle.

Verification
REQ-034 Word write: req0=1, we=1, bytew=0, addr0=16'o177714, wdata0=16'h000F, with a responder that pulls nRPLY low while nDOUT=0 -> nAD=~16'o177714 in ADDR, ~16'h000F in DATA, nWTBT=1 in STRB, ack[0] exactly 8 clocks after the grant edge.
REQ-035 Byte write: same as REQ-034 with bytew=1 and wdata0=16'h0055 -> nWTBT=0 during STRB, ack[0].
REQ-036 Read: req1=1, we=0, responder drives nAD=~16'h1234 with nRPLY -> nAD_oe=0 from DATA, rdata=16'h1234 when ack[1] pulses.
REQ-037 Tie: req=2'b11 from reset -> requester 0 served first, then 1; repeat with req=2'b11 -> order 0,1 again.
REQ-038 No responder -> err[grant] pulses TIMEOUT+1 clocks after SYNC; all enables=0, nBSY=1 on the next clock; ack never asserted.
REQ-039 Assert RSTp during STRB -> all outputs match REQ-032 before the next clock edge; the next request completes normally.
